led_pattern_gen: RTL
====================

// Module: led_pattern_gen
// PURPOSE
//  Parametrised LED pattern engine: N_LED outputs driven by a programmable
//  prescaler, four pattern modes and a global PWM brightness. Sits between the
//  board LED pins and control logic, e.g. a range-sensor FSM that picks mode and
//  rate. New settings arrive over a valid/ready port and take effect on a tick.
// PARAMETERS
//  N_LED       5           number of LED outputs (>=1)
//  DIV_W       24          prescaler / cfg_div width
//  PWM_W       4           brightness resolution in bits
//  DEFAULT_DIV 12_000_000  prescaler terminal count after reset
// PORTS
//  CLK          in   1      system clock
//  NRST         in   1      reset, synchronous, active-low
//  cfg_valid    in   1      new configuration offered
//  cfg_ready    out  1      configuration can be accepted
//  cfg_mode     in   2      0 STATIC, 1 ROTATE, 2 BOUNCE, 3 BLINK
//  cfg_div      in   DIV_W  tick period minus one, in CLK cycles
//  cfg_pattern  in   N_LED  seed pattern (STATIC / ROTATE / BLINK)
//  cfg_duty     in   PWM_W  brightness; 0 = off, all-ones = fully on
//  led          out  N_LED  registered LED drive, 1 = lit
//  step         out  1      1-cycle pulse when the pattern advances
// BEHAVIOUR
//  Reset (NRST=0 at CLK edge): mode=ROTATE, div=DEFAULT_DIV, pattern=...0101
//   (bit0=1), duty=all-ones, prescaler=0, pos=0, dir=up, phase=0, pending=0,
//   led=0, step=0, cfg_ready=0. Pending shadow config is discarded.
//  cfg_ready = ~pending, registered; it rises the first cycle after reset.
//  Prescaler: cnt counts 0..div, then wraps to 0 and asserts tick for one
//   cycle. Period = div+1 cycles; div=0 gives a tick every cycle.
//  Handshake: cfg_valid & cfg_ready at an edge latches all cfg_* into shadow
//   regs, pending=1, cfg_ready=0 next cycle. At the next tick: shadow -> active,
//   state re-seeded (rot=pattern, pos=0, dir=up, phase=0), step NOT pulsed,
//   pending=0, so cfg_ready=1 the following cycle. New div counts from this wrap.
//   Valid on the same edge as a tick is captured; it applies at the NEXT tick.
//  Tick with no pending config advances the mode, step=1 for that cycle:
//   STATIC: rot unchanged (step still pulses).
//   ROTATE: rot <= {rot[N_LED-2:0], rot[N_LED-1]} (left rotate; N_LED=1 holds).
//   BOUNCE: one-hot at pos; up: pos+1 until N_LED-1, then dir=down;
//    down: pos-1 until 0, then dir=up. Ends are shown once (0,1,..,N-1,N-2,..,0,1).
//    N_LED=1: pos stays 0.
//   BLINK: phase toggles; image = phase ? 0 : rot.
//  PWM: free-running PWM_W counter pc; on = (duty=={PWM_W{1}}) | (pc < duty).
//  led <= image & {N_LED{on}}, one register stage: led follows state by 1 cycle.
//  Widths: pos is $clog2(N_LED)+1 bits; compare cnt==div, no overflow possible.
//  Mode change mid-bounce restarts at pos=0, dir=up.
// STRUCTURE
//  led_pattern_pkg: mode localparams (MODE_STATIC/ROTATE/BOUNCE/BLINK, 2 bits),
//   default-pattern function (alternating, bit0=1) used by reset.
//  Sub-module led_tick_div (DIV_W): cnt, tick, sync clear; instantiated once.
//  Top holds cfg shadow/handshake, mode FSM (rot, pos, dir, phase), PWM, led reg.
// TESTING  (N_LED=4, DIV_W=8, PWM_W=4, DEFAULT_DIV=3)
//  1 Reset release, no cfg -> led=0101,1010,0101 changing every 4 cycles;
//    step pulses every 4th cycle; cfg_ready=1 from the 1st cycle after reset.
//  2 cfg mode=BOUNCE div=0 duty=F -> after apply tick, led per cycle
//    0001,0010,0100,1000,0100,0010,0001,0010; no step on the apply tick.
//  3 cfg mode=BLINK pattern=1001 div=1 -> led 1001,0000,1001 every 2 cycles;
//    second cfg_valid while pending -> cfg_ready=0, held until apply.
//  4 STATIC pattern=1111 duty=4 -> each LED high 4 of every 16 cycles;
//    duty=0 -> led=0000 always; duty=F -> led=1111 always.
//  5 NRST low for 1 cycle while pending -> shadow discarded, defaults restored,
//    led=0 that cycle, ROTATE 0101 resumes.
//  6 cfg_valid on a tick edge -> config applied on following tick, not same one.

Source files
------------

// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: mode encodings, bounce direction and reset pattern for the LED pattern engine
package led_pattern_pkg;
  typedef enum logic [1:0] {MODE_STATIC, MODE_ROTATE, MODE_BOUNCE, MODE_BLINK} mode_e;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
  // Alternating ...0101 with bit0 lit; callers truncate to their LED count.
  function automatic logic [63:0] default_pattern();
    return {32{2'b01}};
  endfunction
endpackage

// File: rtl/led_tick_div.sv
// led_tick_div: programmable prescaler producing one tick per div+1 cycles
//   CLK, NRST  clock, synchronous active-low clear of the count
//   div        terminal count (period minus one)
//   tick       high during the cycle whose edge wraps the count to zero
module led_tick_div #(
  parameter int DIV_W = 24
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = cnt_q == div;
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge CLK) cnt_q <= !NRST ? '0 : cnt_d;
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: LED pattern engine with prescaler, four modes and PWM brightness
//   CLK, NRST               clock, synchronous active-low reset
//   cfg_valid / cfg_ready   configuration handshake; accepted config applies on the next tick
//   cfg_mode/div/pattern/duty  mode, tick period minus one, seed pattern, brightness
//   led                     registered LED drive, 1 = lit
//   step                    one-cycle pulse when the pattern advances
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int N_LED       = 5,
  parameter int DIV_W       = 24,
  parameter int PWM_W       = 4,
  parameter int DEFAULT_DIV = 12_000_000
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [N_LED-1:0] cfg_pattern,
  input  logic [PWM_W-1:0] cfg_duty,
  output logic [N_LED-1:0] led,
  output logic             step
);
  localparam int PW = $clog2(N_LED) + 1;
  localparam logic [N_LED-1:0] DEF_PAT = N_LED'(default_pattern());
  mode_e            mode_q, mode_d, sh_mode_q, sh_mode_d;
  logic [DIV_W-1:0] div_q, div_d, sh_div_q, sh_div_d;
  logic [N_LED-1:0] rot_q, rot_d, sh_pat_q, sh_pat_d, led_q, led_d, image;
  logic [PWM_W-1:0] duty_q, duty_d, sh_duty_q, sh_duty_d, pc_q, pc_d;
  logic [PW-1:0]    pos_q, pos_d;
  dir_e             dir_q, dir_d, dir_n;
  logic             phase_q, phase_d, pend_q, pend_d, ready_q, ready_d, step_q, step_d;
  logic             tick, accept, apply, adv, on;
  led_tick_div #(.DIV_W(DIV_W)) u_div (
    .CLK  (CLK),
    .NRST (NRST),
    .div  (div_q),
    .tick (tick)
  );
  always_comb begin
    accept    = cfg_valid & ready_q;
    apply     = tick & pend_q;
    adv       = tick & ~pend_q;
    image     = mode_q == MODE_BOUNCE ? N_LED'(1) << pos_q
              : (mode_q == MODE_BLINK && phase_q) ? '0 : rot_q;
    on        = &duty_q | (pc_q < duty_q);
    // Flip direction on the tick that leaves an end, so each end is shown once.
    dir_n     = dir_q == DIR_DOWN ? (pos_q == '0 ? DIR_UP : DIR_DOWN)
              : (pos_q == PW'(N_LED - 1) ? DIR_DOWN : DIR_UP);
    mode_d    = apply ? sh_mode_q : mode_q;
    div_d     = apply ? sh_div_q : div_q;
    duty_d    = apply ? sh_duty_q : duty_q;
    rot_d     = apply ? sh_pat_q
              : (adv && mode_q == MODE_ROTATE) ? (rot_q << 1) | (rot_q >> (N_LED - 1)) : rot_q;
    pos_d     = apply ? '0
              : (adv && mode_q == MODE_BOUNCE && N_LED > 1) ? (dir_n == DIR_DOWN ? pos_q - 1'b1 : pos_q + 1'b1)
              : pos_q;
    dir_d     = apply ? DIR_UP : (adv && mode_q == MODE_BOUNCE) ? dir_n : dir_q;
    phase_d   = apply ? 1'b0 : phase_q ^ (adv && mode_q == MODE_BLINK);
    pend_d    = apply ? 1'b0 : pend_q | accept;
    ready_d   = ~pend_d;
    sh_mode_d = accept ? mode_e'(cfg_mode) : sh_mode_q;
    sh_div_d  = accept ? cfg_div : sh_div_q;
    sh_pat_d  = accept ? cfg_pattern : sh_pat_q;
    sh_duty_d = accept ? cfg_duty : sh_duty_q;
    pc_d      = pc_q + 1'b1;
    step_d    = adv;
    led_d     = image & {N_LED{on}};
  end
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      mode_q    <= MODE_ROTATE;
      div_q     <= DIV_W'(DEFAULT_DIV);
      duty_q    <= '1;
      rot_q     <= DEF_PAT;
      pos_q     <= '0;
      dir_q     <= DIR_UP;
      phase_q   <= 1'b0;
      pend_q    <= 1'b0;
      ready_q   <= 1'b0;
      sh_mode_q <= MODE_ROTATE;
      sh_div_q  <= '0;
      sh_pat_q  <= '0;
      sh_duty_q <= '0;
      pc_q      <= '0;
      step_q    <= 1'b0;
      led_q     <= '0;
    end else begin
      mode_q    <= mode_d;
      div_q     <= div_d;
      duty_q    <= duty_d;
      rot_q     <= rot_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      phase_q   <= phase_d;
      pend_q    <= pend_d;
      ready_q   <= ready_d;
      sh_mode_q <= sh_mode_d;
      sh_div_q  <= sh_div_d;
      sh_pat_q  <= sh_pat_d;
      sh_duty_q <= sh_duty_d;
      pc_q      <= pc_d;
      step_q    <= step_d;
      led_q     <= led_d;
    end
  end
  assign cfg_ready = ready_q;
  assign step      = step_q;
  assign led       = led_q;
endmodule
